// File: rtl/rl_lj_force_accumulator.sv
// rl_lj_force_accumulator
//   Accumulates Lennard-Jones pair forces. The home-particle sum is kept in
//   running X/Y/Z registers. The same force is subtracted from a per-neighbor
//   cache (Newton's third law), which is drained to nb_force_* on flush.
//   Optional macro FORCE_ACC_SATURATE_EN: sums clamp on overflow instead of
//   wrapping.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ref_particle_id           home particle of the incoming pair force
//   neighbor_particle_id      neighbor particle of the incoming pair force
//   LJ_Force_X/Y/Z            pair force on the home particle
//   forceoutput_valid         input qualifier (accepted only while accum_ready)
//   flush                     end of evaluation: emit all sums
//   accum_ready               high only while accumulating
//   ref_force_*               completed home-particle sums
//   nb_force_*                drained neighbor sums
//   dropped_input             sticky: valid seen while not ready
//   done                      one-cycle pulse when the drain completes
module rl_lj_force_accumulator #(
  parameter int DATA_WIDTH              = 32,
  parameter int PARTICLE_ID_WIDTH       = 20,
  parameter int NEIGHBOR_PARTICLE_NUM   = 100,
  parameter int NEIGHBOR_RAM_ADDR_WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_id,
  input  logic [PARTICLE_ID_WIDTH-1:0] neighbor_particle_id,
  input  logic [DATA_WIDTH-1:0]        LJ_Force_X,
  input  logic [DATA_WIDTH-1:0]        LJ_Force_Y,
  input  logic [DATA_WIDTH-1:0]        LJ_Force_Z,
  input  logic                         forceoutput_valid,
  input  logic                         flush,
  output logic                         accum_ready,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_force_id,
  output logic [DATA_WIDTH-1:0]        ref_force_X,
  output logic [DATA_WIDTH-1:0]        ref_force_Y,
  output logic [DATA_WIDTH-1:0]        ref_force_Z,
  output logic                         ref_force_valid,
  output logic [PARTICLE_ID_WIDTH-1:0] nb_force_id,
  output logic [DATA_WIDTH-1:0]        nb_force_X,
  output logic [DATA_WIDTH-1:0]        nb_force_Y,
  output logic [DATA_WIDTH-1:0]        nb_force_Z,
  output logic                         nb_force_valid,
  output logic                         dropped_input,
  output logic                         done
);
  localparam int DW  = DATA_WIDTH;
  localparam int PW  = PARTICLE_ID_WIDTH;
  localparam int AW  = NEIGHBOR_RAM_ADDR_WIDTH;
  localparam int NUM = NEIGHBOR_PARTICLE_NUM;
  localparam logic [AW-1:0] LAST = AW'(NUM - 1);

  typedef enum logic [2:0] {S_CLEAR, S_ACCUM, S_FLUSH_WAIT, S_DRAIN, S_DONE} state_e;

  // a +/- b in DW-bit two's complement, wrapping or clamping.
  function automatic logic [DW-1:0] acc(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic sub);
    logic [DW-1:0] s;
    s = sub ? (a - b) : (a + b);
`ifdef FORCE_ACC_SATURATE_EN
    // Overflow: operands effectively same sign and result sign flipped.
    if ((a[DW-1] == (b[DW-1] ^ sub)) && (s[DW-1] != a[DW-1]))
      s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return s;
  endfunction

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            accept, in_range;

  // Neighbor cache: three lanes, synchronous read, read-before-write.
  logic [DW-1:0]   mem_x [NUM];
  logic [DW-1:0]   mem_y [NUM];
  logic [DW-1:0]   mem_z [NUM];
  logic [DW-1:0]   rd_x_q, rd_y_q, rd_z_q;
  logic [AW-1:0]   raddr, waddr;
  logic            we;
  logic [DW-1:0]   wx, wy, wz;

  // Stage 1 (read issued) and stage-2 result kept for forwarding.
  logic            s1_vld_q, s2_vld_q;
  logic [AW-1:0]   s1_addr_q, s2_addr_q;
  logic [DW-1:0]   s1_x_q, s1_y_q, s1_z_q, s2_x_q, s2_y_q, s2_z_q;
  logic [DW-1:0]   old_x, old_y, old_z, new_x, new_y, new_z;
  logic            fwd;

  // Home sum
  logic            act_q;
  logic [PW-1:0]   hid_q;
  logic [DW-1:0]   hx_q, hy_q, hz_q;

  logic [PW-1:0]   ref_id_q, nb_id_q;
  logic [DW-1:0]   ref_x_q, ref_y_q, ref_z_q;
  logic            ref_vld_q, nb_vld_q, ready_q, dropped_q, done_q;

  assign accept   = forceoutput_valid && ready_q;
  assign in_range = neighbor_particle_id < PW'(NUM);

  // The RAM read of the previous cycle misses the write made in that same
  // cycle, so a back-to-back hit on the same address takes the stage-2 value.
  assign fwd   = s2_vld_q && (s2_addr_q == s1_addr_q);
  assign old_x = fwd ? s2_x_q : rd_x_q;
  assign old_y = fwd ? s2_y_q : rd_y_q;
  assign old_z = fwd ? s2_z_q : rd_z_q;
  assign new_x = acc(old_x, s1_x_q, 1'b1);
  assign new_y = acc(old_y, s1_y_q, 1'b1);
  assign new_z = acc(old_z, s1_z_q, 1'b1);

  assign raddr = (state_q == S_DRAIN) ? cnt_q : neighbor_particle_id[AW-1:0];

  // Single write port: zero fill in CLEAR / DRAIN, else the stage-2 update.
  always_comb begin
    we    = 1'b0;
    waddr = cnt_q;
    wx    = '0;
    wy    = '0;
    wz    = '0;
    if (state_q == S_CLEAR || state_q == S_DRAIN) begin
      we = 1'b1;
    end else if (s1_vld_q) begin
      we    = 1'b1;
      waddr = s1_addr_q;
      wx    = new_x;
      wy    = new_y;
      wz    = new_z;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_x[waddr] <= wx;
      mem_y[waddr] <= wy;
      mem_z[waddr] <= wz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_x_q <= '0;
      rd_y_q <= '0;
      rd_z_q <= '0;
    end else begin
      rd_x_q <= mem_x[raddr];
      rd_y_q <= mem_y[raddr];
      rd_z_q <= mem_z[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_z_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_x_q    <= '0;
      s2_y_q    <= '0;
      s2_z_q    <= '0;
      act_q     <= 1'b0;
      hid_q     <= '0;
      hx_q      <= '0;
      hy_q      <= '0;
      hz_q      <= '0;
      ref_id_q  <= '0;
      ref_x_q   <= '0;
      ref_y_q   <= '0;
      ref_z_q   <= '0;
      ref_vld_q <= 1'b0;
      nb_id_q   <= '0;
      nb_vld_q  <= 1'b0;
      ready_q   <= 1'b0;
      dropped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ref_vld_q <= 1'b0;
      done_q    <= 1'b0;
      if (forceoutput_valid && !ready_q) dropped_q <= 1'b1;

      s1_vld_q  <= accept && in_range;
      s1_addr_q <= neighbor_particle_id[AW-1:0];
      s1_x_q    <= LJ_Force_X;
      s1_y_q    <= LJ_Force_Y;
      s1_z_q    <= LJ_Force_Z;
      s2_vld_q  <= s1_vld_q;
      s2_addr_q <= s1_addr_q;
      s2_x_q    <= new_x;
      s2_y_q    <= new_y;
      s2_z_q    <= new_z;

      nb_vld_q  <= (state_q == S_DRAIN);
      nb_id_q   <= PW'(cnt_q);

      if (accept) begin
        act_q <= 1'b1;
        if (!act_q || ref_particle_id == hid_q) begin
          hx_q <= acc(act_q ? hx_q : '0, LJ_Force_X, 1'b0);
          hy_q <= acc(act_q ? hy_q : '0, LJ_Force_Y, 1'b0);
          hz_q <= acc(act_q ? hz_q : '0, LJ_Force_Z, 1'b0);
        end else begin
          ref_vld_q <= 1'b1;
          ref_id_q  <= hid_q;
          ref_x_q   <= hx_q;
          ref_y_q   <= hy_q;
          ref_z_q   <= hz_q;
          hx_q      <= LJ_Force_X;
          hy_q      <= LJ_Force_Y;
          hz_q      <= LJ_Force_Z;
        end
        hid_q <= ref_particle_id;
      end

      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= S_ACCUM;
            ready_q <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (flush) begin
            state_q <= S_FLUSH_WAIT;
            ready_q <= 1'b0;
          end
        end
        S_FLUSH_WAIT: begin
          if (!s1_vld_q) begin
            if (act_q) begin
              ref_vld_q <= 1'b1;
              ref_id_q  <= hid_q;
              ref_x_q   <= hx_q;
              ref_y_q   <= hy_q;
              ref_z_q   <= hz_q;
            end
            act_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == LAST) state_q <= S_DONE;
        end
        default: begin  // S_DONE
          done_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_ACCUM;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign accum_ready     = ready_q;
  assign ref_force_id    = ref_id_q;
  assign ref_force_X     = ref_x_q;
  assign ref_force_Y     = ref_y_q;
  assign ref_force_Z     = ref_z_q;
  assign ref_force_valid = ref_vld_q;
  assign nb_force_id     = nb_id_q;
  assign nb_force_X      = rd_x_q;
  assign nb_force_Y      = rd_y_q;
  assign nb_force_Z      = rd_z_q;
  assign nb_force_valid  = nb_vld_q;
  assign dropped_input   = dropped_q;
  assign done            = done_q;
endmodule
